// File: rtl/fb_scanout.sv
// fb_scanout: VGA scan-out engine for the 320x240x3-bit game framebuffer.
//
// Reads the framebuffer through a synchronous RAM read port (1-clock latency)
// and produces 640x480@60 Hz VGA timing from the 50 MHz system clock. Every
// framebuffer pixel is shown as a 2x2 block, and the 3-bit colour code is
// expanded to 4 bits per channel.
//
// Optional build macro: SCANLINE_EN
//   Defined   -> on odd output lines a set colour bit drives 4'h7 (scanline look).
//   Undefined -> every line drives 4'hF for a set colour bit.
//   Timing, latency and addressing are identical in both builds.
//
// Ports:
//   clock          in   1   system clock (50 MHz)
//   reset          in   1   asynchronous, active-high
//   ram_address    out  19  framebuffer read address, FB_W*fy + fx (0 when blanked)
//   ram_read_data  in   3   RAM read data, valid one clock after ram_address
//   vga_r/g/b      out  4   colour channels (0 outside the visible area)
//   vga_hs         out  1   horizontal sync, active-low
//   vga_vs         out  1   vertical sync, active-low
//   vga_de         out  1   display enable, high in the visible area
//   frame_start    out  1   one-clock pulse on the pixel-enable clock where the
//                           counters wrap to h=0, v=0 (not pipeline-delayed)
//
// Pipeline (every register advances only on the pixel enable):
//   stage 0: h/v counters and combinational decode
//   stage 1: ram_address + delayed active/sync
//   stage 2: captured RAM data + delayed active/sync
//   stage 3: output pins
// There is no handshake: the RAM answers every read with fixed latency.

module fb_scanout #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int FB_W     = 320
) (
  input  logic        clock,
  input  logic        reset,
  output logic [18:0] ram_address,
  input  logic [2:0]  ram_read_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Counters are 10 bits wide; totals up to 1024 are supported.
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]    V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]    HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]    HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]    VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]    VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [18:0]   FB_W_C   = 19'(FB_W);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic          pe;
  logic [9:0]    h;
  logic [9:0]    v;
  logic [18:0]   line_base;
  logic          h_wrap;
  logic          v_wrap;

  // Stage 0 decode
  logic          active0;
  logic          hs0_n;
  logic          vs0_n;
  logic [18:0]   addr0;

  // Stage 1 / 2 pipeline
  logic          act1, hs1, vs1;
  logic          act2, hs2, vs2;
  logic [2:0]    data2;
  logic [3:0]    lvl;

  // Pixel enable divider
  assign pe = (div == DIV_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (pe) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign h_wrap = (h == H_LAST);
  assign v_wrap = (v == V_LAST);

  // Counters. line_base always equals FB_W*(v>>1) for the current v: it
  // steps by one framebuffer row whenever v moves onto an even line
  // (v currently odd), replacing a multiplier.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h         <= '0;
      v         <= '0;
      line_base <= '0;
    end else if (pe) begin
      if (h_wrap) begin
        h <= '0;
        if (v_wrap) begin
          v         <= '0;
          line_base <= '0;
        end else begin
          v <= v + 10'd1;
          if (v[0]) line_base <= line_base + FB_W_C;
        end
      end else begin
        h <= h + 10'd1;
      end
    end
  end

  always_comb begin
    active0 = (h < H_ACT) && (v < V_ACT);
    hs0_n   = !((h >= HS_BEG) && (h < HS_END));
    vs0_n   = !((v >= VS_BEG) && (v < VS_END));
    addr0   = line_base + 19'(h[9:1]);
  end

`ifdef SCANLINE_EN
  // Line parity travels with the pixel so the dimming lines up with RGB.
  logic vodd1, vodd2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vodd1 <= 1'b0;
      vodd2 <= 1'b0;
    end else if (pe) begin
      vodd1 <= v[0];
      vodd2 <= vodd1;
    end
  end

  assign lvl = vodd2 ? 4'h7 : 4'hF;
`else
  assign lvl = 4'hF;
`endif

  // Stages 1..3. With CLK_DIV >= 2 the RAM answer for the address written
  // on one pe is stable by the next pe, so stage 2 can capture it directly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ram_address <= '0;
      act1        <= 1'b0;
      hs1         <= 1'b1;
      vs1         <= 1'b1;
      data2       <= '0;
      act2        <= 1'b0;
      hs2         <= 1'b1;
      vs2         <= 1'b1;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_de      <= 1'b0;
    end else if (pe) begin
      ram_address <= active0 ? addr0 : '0;
      act1        <= active0;
      hs1         <= hs0_n;
      vs1         <= vs0_n;
      data2       <= ram_read_data;
      act2        <= act1;
      hs2         <= hs1;
      vs2         <= vs1;
      vga_r       <= act2 ? ({4{data2[2]}} & lvl) : 4'h0;
      vga_g       <= act2 ? ({4{data2[1]}} & lvl) : 4'h0;
      vga_b       <= act2 ? ({4{data2[0]}} & lvl) : 4'h0;
      vga_hs      <= hs2;
      vga_vs      <= vs2;
      vga_de      <= act2;
    end
  end

  // High for exactly the clock following the wrap edge; cleared on the next
  // clock because pe cannot be high two clocks in a row.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pe && h_wrap && v_wrap;
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: directed self-checking bench for fb_scanout.
// The DUT is built with a reduced raster (48x18 pixels total, 32x12 visible,
// 16-pixel framebuffer rows) so whole frames fit in a short run; expected
// values are derived from those bench-side constants.

module tb_fb_scanout;

  localparam int CD  = 2;
  localparam int HA  = 32;
  localparam int HFP = 4;
  localparam int HS  = 8;
  localparam int HBP = 4;
  localparam int VA  = 12;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VBP = 2;
  localparam int FBW = 16;
  localparam int HT  = HA + HFP + HS + HBP;   // 48
  localparam int VT  = VA + VFP + VS + VBP;   // 18
  localparam int FT  = HT * VT;               // pixels per frame
  localparam int FCLK = 2 * FT;               // clocks per frame

  logic        clock;
  logic        reset;
  logic [18:0] ram_address;
  logic [2:0]  ram_read_data;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_de, frame_start;

  int checks = 0;
  int errors = 0;
  int ram_mode = 0;

  // Captured frame, indexed by counter pixel k = v*HT + h
  logic [11:0] obs_rgb  [FT];
  logic        obs_hs   [FT];
  logic        obs_vs   [FT];
  logic        obs_de   [FT];
  logic [18:0] obs_addr [FT];
  int          hs_clk, vs_clk, de_clk, fs_clk;
  logic        fs_end;

  fb_scanout #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .FB_W(FBW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ram_address(ram_address),
    .ram_read_data(ram_read_data),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .vga_hs(vga_hs),
    .vga_vs(vga_vs),
    .vga_de(vga_de),
    .frame_start(frame_start)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #10 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1);
  end

  // ---------------- RAM model and reference ----------------
  function automatic logic [2:0] ram_fn(int mode, logic [18:0] a);
    case (mode)
      1:       return (a == 19'd0) ? 3'b100 : 3'b000;
      2:       return a[2:0];
      3:       return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  always @(posedge clock) ram_read_data <= ram_fn(ram_mode, ram_address);

  function automatic logic exp_de(int k);
    int h; int v;
    h = k % HT; v = k / HT;
    return (h < HA) && (v < VA);
  endfunction

  function automatic logic exp_hs(int k);
    int h;
    h = k % HT;
    return !((h >= HA + HFP) && (h < HA + HFP + HS));
  endfunction

  function automatic logic exp_vs(int k);
    int v;
    v = k / HT;
    return !((v >= VA + VFP) && (v < VA + VFP + VS));
  endfunction

  function automatic logic [18:0] exp_addr(int k);
    int h; int v;
    h = k % HT; v = k / HT;
    if (!exp_de(k)) return 19'd0;
    return 19'(FBW * (v / 2) + h / 2);
  endfunction

  function automatic logic [11:0] exp_rgb(int k, int mode);
    int v; logic [2:0] c; logic [3:0] lvl;
    v = k / HT;
    if (!exp_de(k)) return 12'h000;
    c = ram_fn(mode, exp_addr(k));
    lvl = 4'hF;
`ifdef SCANLINE_EN
    if (v % 2 == 1) lvl = 4'h7;
`endif
    return {c[2] ? lvl : 4'h0, c[1] ? lvl : 4'h0, c[0] ? lvl : 4'h0};
  endfunction

  // ---------------- driver tasks ----------------
  // Leaves the bench on the negedge where frame_start is seen high.
  task automatic sync_frame(input string name);
    int n;
    n = 0;
    while (!frame_start && n < FCLK + 16) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL %s sync: frame_start not seen within %0d clocks, actual=%b required=1",
               name, FCLK + 16, frame_start);
    end
  endtask

  // Records one frame starting at the frame_start negedge (t=0). Pins carry
  // counter pixel k at t=2k+6, ram_address carries pixel k at t=2k+2.
  task automatic capture_frame();
    int kp; int ka;
    hs_clk = 0; vs_clk = 0; de_clk = 0; fs_clk = 0;
    for (int t = 0; t < FCLK; t++) begin
      if (!vga_hs) hs_clk++;
      if (!vga_vs) vs_clk++;
      if (vga_de) de_clk++;
      if (frame_start) fs_clk++;
      if (t % 2 == 0) begin
        kp = (t / 2 - 3 + FT) % FT;
        ka = (t / 2 - 1 + FT) % FT;
        obs_rgb[kp]  = {vga_r, vga_g, vga_b};
        obs_hs[kp]   = vga_hs;
        obs_vs[kp]   = vga_vs;
        obs_de[kp]   = vga_de;
        obs_addr[ka] = ram_address;
      end
      @(negedge clock);
    end
    fs_end = frame_start;
  endtask

  // Counts posedges from a reset release (done at a negedge) to frame_start.
  task automatic clocks_to_frame_start(output int n);
    n = 0;
    while (n < 3 * FCLK) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (frame_start) break;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    ram_mode = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({vga_r, vga_g, vga_b} !== 12'h000) begin
      errors++; $display("FAIL reset_rgb actual=%h required=000", {vga_r, vga_g, vga_b});
    end
    checks++;
    if (vga_hs !== 1'b1) begin errors++; $display("FAIL reset_hs actual=%b required=1", vga_hs); end
    checks++;
    if (vga_vs !== 1'b1) begin errors++; $display("FAIL reset_vs actual=%b required=1", vga_vs); end
    checks++;
    if (vga_de !== 1'b0) begin errors++; $display("FAIL reset_de actual=%b required=0", vga_de); end
    checks++;
    if (frame_start !== 1'b0) begin
      errors++; $display("FAIL reset_fs actual=%b required=0", frame_start);
    end
    checks++;
    if (ram_address !== 19'd0) begin
      errors++; $display("FAIL reset_addr actual=%0d required=0", ram_address);
    end
  endtask

  task automatic test_frame_timing();
    int n; int bad; int first;
    reset = 1'b0;
    clocks_to_frame_start(n);
    checks++;
    if (n !== FCLK) begin
      errors++; $display("FAIL first_frame_start clocks actual=%0d required=%0d", n, FCLK);
    end
    capture_frame();
    checks++;
    if (fs_end !== 1'b1) begin
      errors++; $display("FAIL frame_period frame_start at +%0d clocks actual=%b required=1", FCLK, fs_end);
    end
    checks++;
    if (fs_clk !== 1) begin errors++; $display("FAIL fs_pulses actual=%0d required=1", fs_clk); end
    checks++;
    if (hs_clk !== VT * HS * CD) begin
      errors++; $display("FAIL hs_low_clocks actual=%0d required=%0d", hs_clk, VT * HS * CD);
    end
    checks++;
    if (vs_clk !== VS * HT * CD) begin
      errors++; $display("FAIL vs_low_clocks actual=%0d required=%0d", vs_clk, VS * HT * CD);
    end
    checks++;
    if (de_clk !== VA * HA * CD) begin
      errors++; $display("FAIL de_high_clocks actual=%0d required=%0d", de_clk, VA * HA * CD);
    end
    bad = 0; first = -1;
    for (int k = 0; k < FT; k++) begin
      if (obs_hs[k] !== exp_hs(k) || obs_vs[k] !== exp_vs(k) || obs_de[k] !== exp_de(k) ||
          obs_rgb[k] !== 12'h000) begin
        bad++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL timing_frame bad pixels actual=%0d required=0 (first h=%0d v=%0d)",
                         bad, first % HT, first / HT);
    end
  endtask

  task automatic test_single_red();
    int bad;
    ram_mode = 1;
    sync_frame("single_red");
    capture_frame();
    checks++;
    if (obs_rgb[0] !== 12'hF00) begin errors++; $display("FAIL red_px00 actual=%h required=F00", obs_rgb[0]); end
    checks++;
    if (obs_rgb[1] !== 12'hF00) begin errors++; $display("FAIL red_px10 actual=%h required=F00", obs_rgb[1]); end
    checks++;
    if (obs_rgb[HT] !== 12'hF00) begin errors++; $display("FAIL red_px01 actual=%h required=F00", obs_rgb[HT]); end
    checks++;
    if (obs_rgb[HT + 1] !== 12'hF00) begin
      errors++; $display("FAIL red_px11 actual=%h required=F00", obs_rgb[HT + 1]);
    end
    checks++;
    if (obs_rgb[2] !== 12'h000) begin errors++; $display("FAIL red_px20 actual=%h required=000", obs_rgb[2]); end
    checks++;
    if (obs_rgb[HA] !== 12'h000 || obs_de[HA] !== 1'b0) begin
      errors++; $display("FAIL red_blank actual=%h/%b required=000/0", obs_rgb[HA], obs_de[HA]);
    end
    bad = 0;
    for (int k = 0; k < FT; k++) if (obs_rgb[k] !== exp_rgb(k, 1)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL red_frame bad pixels actual=%0d required=0", bad); end
  endtask

  task automatic test_address();
    int bad; int kmax;
    ram_mode = 0;
    sync_frame("address");
    capture_frame();
    kmax = (VA - 1) * HT + HA - 1;
    checks++;
    if (obs_addr[2 * HT] !== 19'(FBW)) begin
      errors++; $display("FAIL addr_v2_h0 actual=%0d required=%0d", obs_addr[2 * HT], FBW);
    end
    checks++;
    if (obs_addr[3 * HT + 5] !== 19'(FBW + 2)) begin
      errors++; $display("FAIL addr_v3_h5 actual=%0d required=%0d", obs_addr[3 * HT + 5], FBW + 2);
    end
    checks++;
    if (obs_addr[kmax] !== 19'(FBW * (VA / 2) - 1)) begin
      errors++; $display("FAIL addr_max actual=%0d required=%0d", obs_addr[kmax], FBW * (VA / 2) - 1);
    end
    checks++;
    if (obs_addr[HA] !== 19'd0) begin errors++; $display("FAIL addr_hblank actual=%0d required=0", obs_addr[HA]); end
    checks++;
    if (obs_addr[VA * HT + 3] !== 19'd0) begin
      errors++; $display("FAIL addr_vblank actual=%0d required=0", obs_addr[VA * HT + 3]);
    end
    bad = 0;
    for (int k = 0; k < FT; k++) if (obs_addr[k] !== exp_addr(k)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL addr_frame bad pixels actual=%0d required=0", bad); end
  endtask

  task automatic test_pattern();
    int bad; int first;
    ram_mode = 2;
    sync_frame("pattern");
    capture_frame();
    checks++;
    if (obs_rgb[14] !== 12'hFFF) begin errors++; $display("FAIL pat_white actual=%h required=FFF", obs_rgb[14]); end
    checks++;
    if (obs_rgb[6] !== 12'h0FF) begin errors++; $display("FAIL pat_cyan actual=%h required=0FF", obs_rgb[6]); end
    bad = 0; first = -1;
    for (int k = 0; k < FT; k++) begin
      if (obs_rgb[k] !== exp_rgb(k, 2) || obs_de[k] !== exp_de(k)) begin
        bad++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL pat_frame bad pixels actual=%0d required=0 (first h=%0d v=%0d)",
                         bad, first % HT, first / HT);
    end
  endtask

  task automatic test_mid_reset();
    int n; int bad;
    ram_mode = 2;
    sync_frame("mid_reset");
    // advance to counter pixel h=20, v=5
    repeat (2 * (5 * HT + 20)) @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, frame_start} !== {12'h000, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL midrst_outputs actual=%h/%b%b%b%b required=000/1100",
                         {vga_r, vga_g, vga_b}, vga_hs, vga_vs, vga_de, frame_start);
    end
    checks++;
    if (ram_address !== 19'd0) begin errors++; $display("FAIL midrst_addr actual=%0d required=0", ram_address); end
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({vga_r, vga_g, vga_b, vga_de} !== 13'h0) begin
      errors++; $display("FAIL midrst_held actual=%h required=0", {vga_r, vga_g, vga_b, vga_de});
    end
    reset = 1'b0;
    clocks_to_frame_start(n);
    checks++;
    if (n !== FCLK) begin
      errors++; $display("FAIL midrst_frame_start clocks actual=%0d required=%0d", n, FCLK);
    end
    capture_frame();
    bad = 0;
    for (int k = 0; k < FT; k++) if (obs_rgb[k] !== exp_rgb(k, 2)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL midrst_frame bad pixels actual=%0d required=0", bad); end
  endtask

  task automatic test_scanline();
    int bad;
    logic [11:0] odd_exp;
`ifdef SCANLINE_EN
    odd_exp = 12'h770;
`else
    odd_exp = 12'hFF0;
`endif
    ram_mode = 3;
    sync_frame("scanline");
    capture_frame();
    checks++;
    if (obs_rgb[0] !== 12'hFF0) begin errors++; $display("FAIL scan_even actual=%h required=FF0", obs_rgb[0]); end
    checks++;
    if (obs_rgb[HT] !== odd_exp) begin
      errors++; $display("FAIL scan_odd actual=%h required=%h", obs_rgb[HT], odd_exp);
    end
    checks++;
    if (obs_rgb[2 * HT + 3] !== 12'hFF0) begin
      errors++; $display("FAIL scan_even2 actual=%h required=FF0", obs_rgb[2 * HT + 3]);
    end
    bad = 0;
    for (int k = 0; k < FT; k++) if (obs_rgb[k] !== exp_rgb(k, 3)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL scan_frame bad pixels actual=%0d required=0", bad); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    test_reset();
    test_frame_timing();
    test_single_red();
    test_address();
    test_pattern();
    test_mid_reset();
    test_scanline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
